// File: rtl/von_neumann_pkg.sv
// Shared definitions for the von_neumann CPU datapath: default word/address
// widths used by AC and memory, and the store sequencer state encoding.
package von_neumann_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2
  } store_state_t;

endpackage : von_neumann_pkg

// File: rtl/ac_store_ctrl_ack_timer.sv
// Clearable, saturating wait counter with a TIMEOUT compare; shared by the
// store and load sequencers to bound acknowledge waits.
module ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flags the increment that takes the count to TIMEOUT.
  assign expired_o = inc_i && !clr_i && (cnt_q >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ack_timer

// File: rtl/ac_store_ctrl.sv
// AC write-back sequencer: captures AC data and address on a store request,
// then drives one registered memory write cycle with ack/timeout handling.
module ac_store_ctrl
  import von_neumann_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              REST_N,
  input  logic              STORE_REQ,
  input  logic [ADDR_W-1:0] STORE_ADDR,
  input  logic [DATA_W-1:0] AC_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic              MEM_ACK
);

  store_state_t      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic accept;
  logic tmr_inc;
  logic tmr_expired;

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst_n     (REST_N),
    .clr_i     (accept),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    tmr_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (STORE_REQ) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          addr_d  = STORE_ADDR;
          wdata_d = AC_DATA;
          err_d   = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // An ack on the final allowed cycle still counts as success.
        if (MEM_ACK) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state so that no
    // input reaches an output combinationally.
    busy_d = (state_d != ST_IDLE);
    we_d   = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or negedge REST_N) begin
    if (!REST_N) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      // NOTE: the address/data holding registers are reset too, because the
      // memory port must present all-zero outputs while in reset.
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;

endmodule : ac_store_ctrl
